blind_pixel_detect: RTL and testbench

- Calibration-time writer of the blind-pixel table consumed by the blind-pixel correction stage.
- Sits in the video stream as a zero-latency pass-through. When armed, it scans one frame and classifies any pixel outside [reg_thresh_low, reg_thresh_high] as blind.
- Blind-pixel indices are written to the table RAM in ascending order at addresses 1..N. The count N is written last, at address 0.

---
 rtl/blind_pixel_pkg.sv | 34 +++
 rtl/blind_pixel_classify.sv | 27 ++
 rtl/blind_pixel_detect.sv | 153 +++++++++++++++
 tb/tb_blind_pixel_detect.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blind_pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blind_pixel_pkg
// Purpose  : Shared definitions for the blind-pixel detect and correction
//            stages: table layout, detect FSM encoding and correction modes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package blind_pixel_pkg;

    // Table RAM layout: address 0 holds the entry count, entries follow it.
    localparam int ADDR_WIDTH = 8;
    localparam int WORD_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR       = 8'd0;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ENTRY_ADDR = 8'd1;

    // Detect FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SCAN  = 2'd2,
        WRCNT = 2'd3
    } detect_state_t;

    // Correction-stage mode encoding, kept here so both stages agree.
    typedef enum logic [1:0] {
        CORR_BYPASS    = 2'd0,
        CORR_REPLICATE = 2'd1,
        CORR_AVERAGE   = 2'd2,
        CORR_MARK      = 2'd3
    } corr_mode_t;

endpackage
`default_nettype wire

// File: rtl/blind_pixel_classify.sv
`default_nettype none
// ============================================================================
// Module   : blind_pixel_classify
// Purpose  : Threshold comparator flagging a pixel outside the good window.
// Ports    : data_i        - pixel value
//            thresh_low_i  - lowest good value (inclusive)
//            thresh_high_i - highest good value (inclusive)
//            blind_o       - pixel is outside [low, high]
// Revision : 1.0 - initial release
// ============================================================================
module blind_pixel_classify
    import blind_pixel_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] thresh_low_i,
    input  logic [DATA_WIDTH-1:0] thresh_high_i,
    output logic                  blind_o
);

    // With an inverted window (low > high) every value fails one of the two
    // compares, so "all pixels blind" falls out without a special case.
    assign blind_o = (data_i < thresh_low_i) || (data_i > thresh_high_i);

endmodule
`default_nettype wire

// File: rtl/blind_pixel_detect.sv
`default_nettype none
// ============================================================================
// Module   : blind_pixel_detect
// Purpose  : Calibration-time writer of the blind-pixel table. Passes the
//            video stream through with zero latency; when armed it scans one
//            frame, writes blind pixel indices to table addresses 1..N in
//            ascending order and finally writes the count N to address 0.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            ram_write/address/writedata - table RAM write port
//            reg_start, reg_thresh_*  - arm pulse and good-pixel window
//            reg_busy/done/overflow/count - status
//            din_*  / dout_*          - stream sink / source (pass-through)
// Revision : 1.0 - initial release
// ============================================================================
module blind_pixel_detect
    import blind_pixel_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int MAX_ENTRIES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // table RAM write port
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [WORD_WIDTH-1:0] ram_writedata,
    // control / status registers
    input  logic                  reg_start,
    input  logic [DATA_WIDTH-1:0] reg_thresh_low,
    input  logic [DATA_WIDTH-1:0] reg_thresh_high,
    output logic                  reg_busy,
    output logic                  reg_done,
    output logic                  reg_overflow,
    output logic [ADDR_WIDTH-1:0] reg_count,
    // stream sink
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    // stream source
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready
);

    localparam logic [ADDR_WIDTH-1:0] c_MAX_ENTRIES = ADDR_WIDTH'(MAX_ENTRIES);

    detect_state_t         state_q;
    logic [31:0]           pix_cnt_q;
    logic [ADDR_WIDTH-1:0] entry_cnt_q;
    logic                  ram_write_q;
    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic [WORD_WIDTH-1:0] ram_writedata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [ADDR_WIDTH-1:0] count_q;

    logic                  w_blind;
    logic                  w_take;
    logic [31:0]           pix_idx_d;

    // Zero-latency pass-through; the block never stalls the stream.
    assign dout_data          = din_data;
    assign dout_valid         = din_valid;
    assign dout_startofpacket = din_startofpacket;
    assign dout_endofpacket   = din_endofpacket;
    assign din_ready          = dout_ready;

    blind_pixel_classify #(
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_classify (
        .data_i        (din_data),
        .thresh_low_i  (reg_thresh_low),
        .thresh_high_i (reg_thresh_high),
        .blind_o       (w_blind)
    );

    // A beat is classified in SCAN, or in ARMED when it opens a packet.
    // Any SOP restarts indexing at 0, including one arriving mid-scan.
    assign w_take    = din_valid && dout_ready &&
                       ((state_q == SCAN) || ((state_q == ARMED) && din_startofpacket));
    assign pix_idx_d = din_startofpacket ? 32'd0 : pix_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pix_cnt_q       <= '0;
            entry_cnt_q     <= '0;
            ram_write_q     <= 1'b0;
            ram_address_q   <= '0;
            ram_writedata_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            overflow_q      <= 1'b0;
            count_q         <= '0;
        end else begin
            ram_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reg_start) begin
                        state_q     <= ARMED;
                        done_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        entry_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ARMED, SCAN: begin
                    if (w_take) begin
                        pix_cnt_q <= pix_idx_d + 32'd1;
                        if (w_blind) begin
                            if (entry_cnt_q < c_MAX_ENTRIES) begin
                                ram_write_q     <= 1'b1;
                                ram_address_q   <= entry_cnt_q + FIRST_ENTRY_ADDR;
                                ram_writedata_q <= pix_idx_d;
                                entry_cnt_q     <= entry_cnt_q + 8'd1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                        // The entry write for a blind EOP beat lands during
                        // the WRCNT cycle; the count write follows after it.
                        state_q <= din_endofpacket ? WRCNT : SCAN;
                    end
                end
                WRCNT: begin
                    ram_write_q     <= 1'b1;
                    ram_address_q   <= COUNT_ADDR;
                    ram_writedata_q <= {{(WORD_WIDTH-ADDR_WIDTH){1'b0}}, entry_cnt_q};
                    count_q         <= entry_cnt_q;
                    done_q          <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_write     = ram_write_q;
    assign ram_address   = ram_address_q;
    assign ram_writedata = ram_writedata_q;
    assign reg_busy      = busy_q;
    assign reg_done      = done_q;
    assign reg_overflow  = overflow_q;
    assign reg_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_blind_pixel_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_blind_pixel_detect
// Purpose  : Self-checking bench for blind_pixel_detect. Two instances share
//            the stimulus (table depth 255 and 4); a per-cycle reference
//            model and a per-frame expected table check both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blind_pixel_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_start = 1'b0;
    logic [13:0] thr_lo = 14'd0, thr_hi = 14'd0;
    logic [13:0] din_data = 14'd0;
    logic        din_valid = 1'b0, sop = 1'b0, eop = 1'b0, dout_ready = 1'b1;

    logic        o_wr[2];
    logic [7:0]  o_addr[2];
    logic [31:0] o_wd[2];
    logic        o_busy[2], o_done[2], o_ovf[2];
    logic [7:0]  o_cnt[2];
    logic        o_drdy[2];
    logic [13:0] o_dd[2];
    logic        o_dv[2], o_ds[2], o_de[2];

    int n_vec = 0, n_err = 0, cyc = 0;
    int MAXK[2] = '{255, 4};

    blind_pixel_detect #(.DATA_WIDTH(14), .MAX_ENTRIES(255)) u_dut0 (
        .clk(clk), .rst(rst),
        .ram_write(o_wr[0]), .ram_address(o_addr[0]), .ram_writedata(o_wd[0]),
        .reg_start(reg_start), .reg_thresh_low(thr_lo), .reg_thresh_high(thr_hi),
        .reg_busy(o_busy[0]), .reg_done(o_done[0]), .reg_overflow(o_ovf[0]), .reg_count(o_cnt[0]),
        .din_data(din_data), .din_valid(din_valid), .din_startofpacket(sop),
        .din_endofpacket(eop), .din_ready(o_drdy[0]),
        .dout_data(o_dd[0]), .dout_valid(o_dv[0]), .dout_startofpacket(o_ds[0]),
        .dout_endofpacket(o_de[0]), .dout_ready(dout_ready));

    blind_pixel_detect #(.DATA_WIDTH(14), .MAX_ENTRIES(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .ram_write(o_wr[1]), .ram_address(o_addr[1]), .ram_writedata(o_wd[1]),
        .reg_start(reg_start), .reg_thresh_low(thr_lo), .reg_thresh_high(thr_hi),
        .reg_busy(o_busy[1]), .reg_done(o_done[1]), .reg_overflow(o_ovf[1]), .reg_count(o_cnt[1]),
        .din_data(din_data), .din_valid(din_valid), .din_startofpacket(sop),
        .din_endofpacket(eop), .din_ready(o_drdy[1]),
        .dout_data(o_dd[1]), .dout_valid(o_dv[1]), .dout_startofpacket(o_ds[1]),
        .dout_endofpacket(o_de[1]), .dout_ready(dout_ready));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (one per instance) ----------------
    bit          m_wr[2], m_busy[2], m_done[2], m_ovf[2], m_pend[2], m_scan[2];
    int unsigned m_a[2], m_d[2], m_cnt[2], m_ent[2], m_pix[2];

    // write log per instance: address, data, cycle stamp
    int unsigned log0_a[$], log0_d[$], log0_c[$], log1_a[$], log1_d[$], log1_c[$];

    always @(posedge clk) begin
        int unsigned idx;
        cyc++;
        // combinational pass-through, sampled with inputs stable
        for (int k = 0; k < 2; k++) begin
            chk("pass data", o_dd[k], din_data);
            chk("pass ctl", {o_dv[k], o_ds[k], o_de[k]}, {din_valid, sop, eop});
            chk("pass ready", o_drdy[k], dout_ready);
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_wr[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
                m_pend[k] = 0; m_scan[k] = 0; m_cnt[k] = 0; m_ent[k] = 0;
            end else begin
                m_wr[k] = 0;
                if (m_pend[k]) begin
                    m_wr[k] = 1; m_a[k] = 0; m_d[k] = m_ent[k];
                    m_cnt[k] = m_ent[k]; m_done[k] = 1; m_busy[k] = 0; m_pend[k] = 0;
                end else if (!m_busy[k]) begin
                    if (reg_start) begin
                        m_busy[k] = 1; m_done[k] = 0; m_ovf[k] = 0; m_ent[k] = 0; m_scan[k] = 0;
                    end
                end else if (din_valid && dout_ready && (m_scan[k] || sop)) begin
                    idx = sop ? 0 : m_pix[k];
                    m_pix[k] = idx + 1;
                    m_scan[k] = 1;
                    if (din_data < thr_lo || din_data > thr_hi) begin
                        if (m_ent[k] < MAXK[k]) begin
                            m_ent[k]++;
                            m_wr[k] = 1; m_a[k] = m_ent[k]; m_d[k] = idx;
                        end else m_ovf[k] = 1;
                    end
                    if (eop) begin m_scan[k] = 0; m_pend[k] = 1; end
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("ram_write", o_wr[k], m_wr[k]);
            if (m_wr[k]) begin
                chk("ram_address", o_addr[k], m_a[k]);
                chk("ram_writedata", o_wd[k], m_d[k]);
            end
            chk("reg_busy", o_busy[k], m_busy[k]);
            chk("reg_done", o_done[k], m_done[k]);
            chk("reg_overflow", o_ovf[k], m_ovf[k]);
            chk("reg_count", o_cnt[k], m_cnt[k]);
        end
        if (o_wr[0]) begin log0_a.push_back(o_addr[0]); log0_d.push_back(o_wd[0]); log0_c.push_back(cyc); end
        if (o_wr[1]) begin log1_a.push_back(o_addr[1]); log1_d.push_back(o_wd[1]); log1_c.push_back(cyc); end
    end

    // ---------------- stimulus helpers ----------------
    logic [13:0] p_lo = 14'd100, p_hi = 14'd16000;
    int unsigned fr[$], bl[$], ex_a[$], ex_d[$];
    int st_at = -1, rst_at = -1;

    task automatic put(input logic v, input logic [13:0] d, input logic s, input logic e,
                       input logic st, input logic rdy);
        @(negedge clk);
        rst = 0; din_valid = v; din_data = d; sop = s; eop = e;
        reg_start = st; dout_ready = rdy; thr_lo = p_lo; thr_hi = p_hi;
    endtask

    task automatic idle(input int n);
        repeat (n) put(0, 14'($urandom_range(0, 16383)), 0, 0, 0, 1'($urandom_range(0, 1)));
    endtask

    task automatic arm();
        put(0, 14'd0, 0, 0, 1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; din_valid = 0; reg_start = 0;
    endtask

    task automatic clr();
        log0_a.delete(); log0_d.delete(); log0_c.delete();
        log1_a.delete(); log1_d.delete(); log1_c.delete();
        ex_a.delete(); ex_d.delete();
    endtask

    task automatic send_frame(input bit bp, input bit rnd);
        bit r;
        bl.delete();
        for (int i = 0; i < fr.size(); i++) begin
            if (i == rst_at) do_reset();
            if (rnd && $urandom_range(0, 15) == 0) begin
                p_lo = 14'($urandom_range(0, 6000));
                p_hi = 14'($urandom_range(3000, 16383));
            end
            if (bp && $urandom_range(0, 3) == 0) idle(1);
            for (int t = 0; t < 8; t++) begin
                r = (!bp || t == 7) ? 1'b1 : ($urandom_range(0, 2) != 0);
                put(1, 14'(fr[i]), i == 0, i == fr.size() - 1, (i == st_at) && (t == 0), r);
                if (r) break;
            end
            if (fr[i] < p_lo || fr[i] > p_hi) bl.push_back(i);
        end
        st_at = -1; rst_at = -1;
        idle(4);
    endtask

    // Expected table from the list of blind indices, truncated to depth.
    task automatic build_ex(input int k);
        int n;
        ex_a.delete(); ex_d.delete();
        n = (bl.size() < MAXK[k]) ? bl.size() : MAXK[k];
        for (int i = 0; i < n; i++) begin ex_a.push_back(i + 1); ex_d.push_back(bl[i]); end
        ex_a.push_back(0); ex_d.push_back(n);
    endtask

    task automatic cmp_log(input int k, input string nm);
        int unsigned la[$], ld[$];
        if (k == 0) begin la = log0_a; ld = log0_d; end
        else begin la = log1_a; ld = log1_d; end
        chk({nm, " nwrites"}, la.size(), ex_a.size());
        for (int i = 0; i < ex_a.size() && i < la.size(); i++) begin
            chk({nm, " addr"}, la[i], ex_a[i]);
            chk({nm, " data"}, ld[i], ex_d[i]);
        end
    endtask

    task automatic lit(input int unsigned a, input int unsigned d);
        ex_a.push_back(a); ex_d.push_back(d);
    endtask

    task automatic mk_frame(input int len, input int unsigned val);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(val);
    endtask

    task automatic model_tables(input string nm);
        build_ex(0); cmp_log(0, {nm, " tbl0"});
        build_ex(1); cmp_log(1, {nm, " tbl1"});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        idle(2);
        chk("reset busy", o_busy[0], 0);
        chk("reset done", o_done[0], 0);
        chk("reset count", o_cnt[0], 0);
        chk("reset write", o_wr[0], 0);

        // two blind pixels at 3 and 9
        clr(); p_lo = 100; p_hi = 16000;
        mk_frame(16, 5000); fr[3] = 0; fr[9] = 0;
        arm(); idle(1); send_frame(0, 0);
        lit(1, 3); lit(2, 9); lit(0, 2); cmp_log(0, "t1 literal");
        chk("t1 count", o_cnt[0], 2);
        chk("t1 done", o_done[0], 1);
        model_tables("t1");

        // blind EOP: entry write then count write on the next cycle
        clr(); mk_frame(16, 5000); fr[15] = 16383;
        arm(); send_frame(0, 0);
        lit(1, 15); lit(0, 1); cmp_log(0, "t2 literal");
        if (log0_c.size() == 2) chk("t2 write spacing", log0_c[1] - log0_c[0], 1);
        else chk("t2 write stamps", log0_c.size(), 2);

        // no blind pixels
        clr(); mk_frame(20, 777);
        arm(); idle(2); send_frame(0, 0);
        lit(0, 0); cmp_log(0, "t3 literal");
        chk("t3 count", o_cnt[0], 0);

        // six blind pixels: depth-4 instance overflows
        clr(); mk_frame(8, 5000);
        for (int i = 1; i <= 6; i++) fr[i] = 0;
        arm(); send_frame(0, 0);
        lit(1, 1); lit(2, 2); lit(3, 3); lit(4, 4); lit(0, 4); cmp_log(1, "t4 literal");
        chk("t4 overflow1", o_ovf[1], 1);
        chk("t4 overflow0", o_ovf[0], 0);
        chk("t4 count0", o_cnt[0], 6);
        model_tables("t4");

        // frame before arming ignored; arm mid-frame; start during scan ignored
        clr(); mk_frame(8, 5000); fr[2] = 0;
        send_frame(0, 0); idle(2);
        cmp_log(0, "t5 unarmed");
        st_at = 4; send_frame(0, 0);
        cmp_log(0, "t5 midarm");
        st_at = 5; send_frame(0, 0);
        lit(1, 2); lit(0, 1); cmp_log(0, "t5 literal");
        chk("t5 overflow1 cleared", o_ovf[1], 0);

        // reset mid-scan after one entry
        clr(); mk_frame(16, 5000); fr[1] = 0; fr[10] = 0;
        arm(); rst_at = 6; send_frame(0, 0);
        lit(1, 1); cmp_log(0, "t6 literal");
        chk("t6 busy", o_busy[0], 0);
        chk("t6 done", o_done[0], 0);
        chk("t6 count", o_cnt[0], 0);
        clr(); mk_frame(16, 5000); fr[3] = 0; fr[9] = 0;
        arm(); send_frame(0, 0);
        lit(1, 3); lit(2, 9); lit(0, 2); cmp_log(0, "t6 rearm");

        // randomized frames with back-pressure and threshold changes
        for (int r = 0; r < 10; r++) begin
            int len;
            clr();
            len = (r == 0) ? 64 : $urandom_range(2, 70);
            p_lo = 14'($urandom_range(0, 6000));
            p_hi = 14'($urandom_range(3000, 16383));
            fr.delete();
            for (int i = 0; i < len; i++)
                fr.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383)
                                                         : $urandom_range(5000, 9000));
            arm(); idle($urandom_range(0, 3));
            send_frame(1, r != 0);
            model_tables("rand");
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
